// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter sharing the single DRAM cache request port.
// Optional BUSY watchdog enabled by defining DRAM_ARB_TIMEOUT_EN.
module dram_arbiter #(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic              m1_valid,
    input  logic              m0_rw,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ready,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] addr_dram,
    output logic [DATA_W-1:0] din_dram,
    output logic              rw_dram,
    output logic              valid_dram,
    input  logic [DATA_W-1:0] dout_dram,
    input  logic              ready_dram,
    output logic              grant,
    output logic              busy,
    output logic              timeout_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_rw;
    logic              r_valid;
    logic              r_busy;
    logic              r_ready0;
    logic              r_ready1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_req;
    logic              w_sel1;
    logic              w_tmo;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;

    assign w_req  = m0_valid | m1_valid;
    // Port 1 wins alone, or on a tie when port 0 owned the last transaction.
    assign w_sel1 = m1_valid & (~m0_valid | ~r_last_grant);

`ifdef DRAM_ARB_TIMEOUT_EN
    logic [31:0] r_cnt;
    logic        r_timeout;

    assign w_tmo = (r_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 32'd1;
            if (!ready_dram && w_tmo)
                r_timeout <= 1'b1;
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_done  = ready_dram | w_tmo;
    // A watchdog-forced completion returns zero data.
    assign w_rdata = ready_dram ? dout_dram : '0;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_rw         <= 1'b0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_ready0     <= 1'b0;
            r_ready1     <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_grant      <= w_sel1;
                        r_last_grant <= w_sel1;
                        r_addr       <= w_sel1 ? m1_addr  : m0_addr;
                        r_din        <= w_sel1 ? m1_wdata : m0_wdata;
                        r_rw         <= w_sel1 ? m1_rw    : m0_rw;
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_valid <= 1'b0;
                        if (r_grant) begin
                            r_rdata1 <= w_rdata;
                            r_ready1 <= 1'b1;
                        end else begin
                            r_rdata0 <= w_rdata;
                            r_ready0 <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ready0 <= 1'b0;
                    r_ready1 <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addr_dram  = r_addr;
    assign din_dram   = r_din;
    assign rw_dram    = r_rw;
    assign valid_dram = r_valid;
    assign busy       = r_busy;
    assign grant      = r_grant;
    assign m0_ready   = r_ready0;
    assign m1_ready   = r_ready1;
    assign m0_rdata   = r_rdata0;
    assign m1_rdata   = r_rdata1;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed table-driven bench for dram_arbiter, plus reset and idle corner sequences.
module tb_dram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m1_valid, m0_rw, m1_rw;
    logic [26:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [26:0] addr_dram;
    logic [31:0] din_dram;
    logic        rw_dram, valid_dram;
    logic [31:0] dout_dram;
    logic        ready_dram;
    logic        grant, busy, timeout_err;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(27), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .sys_clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m1_valid(m1_valid), .m0_rw(m0_rw), .m1_rw(m1_rw),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ready(m0_ready), .m1_ready(m1_ready), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .addr_dram(addr_dram), .din_dram(din_dram), .rw_dram(rw_dram), .valid_dram(valid_dram),
        .dout_dram(dout_dram), .ready_dram(ready_dram),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        v0, v1, rw0, rw1;
        logic [26:0] a0, a1;
        logic [31:0] w0, w1;
        int          lat;
        logic [31:0] dout;
        logic        g;
        logic [26:0] ea;
        logic        erw;
        logic [31:0] ed;
    } vec_t;

    vec_t        vecs [0:8];
    logic [31:0] exp_rd [0:1];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        logic got;
        @(negedge clk);
        chk("idle_m0_ready", {31'd0, m0_ready}, 32'd0);
        chk("idle_m1_ready", {31'd0, m1_ready}, 32'd0);
        m0_valid = v.v0; m1_valid = v.v1; m0_rw = v.rw0; m1_rw = v.rw1;
        m0_addr = v.a0; m1_addr = v.a1; m0_wdata = v.w0; m1_wdata = v.w1;
        n = 0; got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            n++;
            if (valid_dram) got = 1'b1;
        end
        chk("valid_latency", n, 32'd1);
        chk("grant", {31'd0, grant}, {31'd0, v.g});
        chk("addr_dram", {5'd0, addr_dram}, {5'd0, v.ea});
        chk("din_dram", din_dram, v.ed);
        chk("rw_dram", {31'd0, rw_dram}, {31'd0, v.erw});
        chk("busy_in_busy", {31'd0, busy}, 32'd1);
        // Requester may drop valid and change its inputs while the transaction is in flight.
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = 27'h5555555; m1_addr = 27'h2AAAAAA;
        m0_wdata = 32'hFFFFFFFF; m1_wdata = 32'hFFFFFFFF;
        m0_rw = ~v.rw0; m1_rw = ~v.rw1;
        for (int i = 0; i < v.lat; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, valid_dram}, 32'd1);
            chk("hold_addr", {5'd0, addr_dram}, {5'd0, v.ea});
            chk("hold_din", din_dram, v.ed);
            chk("hold_rw", {31'd0, rw_dram}, {31'd0, v.erw});
        end
        ready_dram = 1'b1; dout_dram = v.dout;
        @(negedge clk);
        ready_dram = 1'b0; dout_dram = 32'h0BAD0BAD;
        exp_rd[v.g] = v.dout;
        chk("resp_m0_ready", {31'd0, m0_ready}, {31'd0, ~v.g});
        chk("resp_m1_ready", {31'd0, m1_ready}, {31'd0, v.g});
        chk("resp_m0_rdata", m0_rdata, exp_rd[0]);
        chk("resp_m1_rdata", m1_rdata, exp_rd[1]);
        chk("resp_valid_low", {31'd0, valid_dram}, 32'd0);
        chk("resp_busy", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 27'h100, 27'h0, 32'h0, 32'h0, 5, 32'hDEADBEEF, 1'b0, 27'h100, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 27'h0, 27'h7FFFFFF, 32'h0, 32'h12345678, 3, 32'hAAAA5555, 1'b1, 27'h7FFFFFF, 1'b1, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 27'h11, 27'h22, 32'h11111111, 32'h22222222, 1, 32'h1, 1'b0, 27'h11, 1'b0, 32'h11111111};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 27'h11, 27'h22, 32'h11111111, 32'h22222222, 1, 32'h2, 1'b1, 27'h22, 1'b0, 32'h22222222};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 27'h11, 27'h22, 32'h11111111, 32'h22222222, 2, 32'h3, 1'b0, 27'h11, 1'b0, 32'h11111111};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 27'h11, 27'h22, 32'h11111111, 32'h22222222, 0, 32'h4, 1'b1, 27'h22, 1'b0, 32'h22222222};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 27'h0, 27'h33, 32'h0, 32'h0, 0, 32'h0BADF00D, 1'b1, 27'h33, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 27'h44, 27'h0, 32'hCAFEF00D, 32'h0, 0, 32'h5A5A5A5A, 1'b0, 27'h44, 1'b1, 32'hCAFEF00D};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 27'h101, 27'h202, 32'h0, 32'h0, 2, 32'h13572468, 1'b0, 27'h101, 1'b0, 32'h0};
        exp_rd[0] = '0; exp_rd[1] = '0;

        rst = 1'b0; ready_dram = 1'b0; dout_dram = '0;
        m0_valid = 1'b0; m1_valid = 1'b0; m0_rw = 1'b0; m1_rw = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid_dram", {31'd0, valid_dram}, 32'd0);
        chk("rst_addr_dram", {5'd0, addr_dram}, 32'd0);
        chk("rst_din_dram", din_dram, 32'd0);
        chk("rst_rw_dram", {31'd0, rw_dram}, 32'd0);
        chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_grant_busy_tmo", {29'd0, grant, busy, timeout_err}, 32'd0);
        rst = 1'b1;

        // Cache strobe while idle must be ignored.
        @(negedge clk);
        ready_dram = 1'b1; dout_dram = 32'hFFFFFFFF;
        @(negedge clk);
        ready_dram = 1'b0;
        @(negedge clk);
        chk("idle_strobe_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        chk("idle_strobe_state", {30'd0, valid_dram, busy}, 32'd0);
        chk("idle_strobe_rdata", m0_rdata | m1_rdata, 32'd0);

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Reset while port 1 is in flight: pending ready must never appear.
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = 27'h77;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, valid_dram}, 32'd1);
        chk("pre_rst_grant", {31'd0, grant}, 32'd1);
        m1_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, valid_dram}, 32'd0);
        chk("midrst_busy_grant", {30'd0, busy, grant}, 32'd0);
        chk("midrst_addr", {5'd0, addr_dram}, 32'd0);
        chk("midrst_rdata", m0_rdata | m1_rdata, 32'd0);
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready || valid_dram) n++;
        end
        chk("postrst_quiet", n, 32'd0);
        do_txn(vecs[8]);

`ifdef DRAM_ARB_TIMEOUT_EN
        @(negedge clk);
        m0_valid = 1'b1; m0_addr = 27'h99; m0_rw = 1'b0;
        @(negedge clk);
        m0_valid = 1'b0;
        chk("tmo_valid", {31'd0, valid_dram}, 32'd1);
        n = 1;
        for (int i = 0; i < 40 && !m0_ready; i++) begin
            @(negedge clk);
            if (!m0_ready) n++;
        end
        chk("tmo_busy_cycles", n, 32'd16);
        chk("tmo_ready", {31'd0, m0_ready}, 32'd1);
        chk("tmo_rdata", m0_rdata, 32'd0);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        exp_rd[0] = '0;
        do_txn(vecs[6]);
        chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
        chk("tmo_err_tied", {31'd0, timeout_err}, 32'd0);
`endif

        m0_valid = 1'b0; m1_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
